// File: rtl/aes_round_ctrl.sv
// Purpose: round sequencer for an iterative AES-128/192/256 encryption datapath (INIT, SUB, MIX, ARK, DONE).
// Latency: done is high 1 + (NR-1)*(2+MC_LAT) + 3 cycles after start is sampled, plus one cycle per key stall.
// Backpressure: key_valid low stalls INIT/ARK in place; start is dropped while busy. Optional abort port: AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
   parameter int NR     = 10,
   parameter int MC_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       key_valid,
`ifdef AES_ROUND_CTRL_ABORT_EN
   input  logic       abort,
`endif
   output logic       busy,
   output logic       done,
   output logic [3:0] round,
   output logic       st_ld,
   output logic [1:0] st_sel,
   output logic       mc_st
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_SUB  = 3'd2,
      S_MIX  = 3'd3,
      S_ARK  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [3:0] NR_L    = 4'(NR);
   localparam logic [1:0] MC_LAST = 2'(MC_LAT - 1);

   // State-register source selects.
   localparam logic [1:0] SEL_IN  = 2'd0;
   localparam logic [1:0] SEL_SB  = 2'd1;
   localparam logic [1:0] SEL_MIX = 2'd2;
   localparam logic [1:0] SEL_KEY = 2'd3;

   state_t     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [1:0] mix_cnt_q, mix_cnt_d;
   logic       abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // Next-state, round index and MixColumns hold counter.
   always_comb begin
      state_d   = state_q;
      round_d   = round_q;
      mix_cnt_d = mix_cnt_q;
      case (state_q)
         S_IDLE: begin
            round_d   = 4'd0;
            mix_cnt_d = 2'd0;
            if (start) begin
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            if (key_valid) begin
               state_d = S_SUB;
               round_d = 4'd1;
            end
         end
         S_SUB: begin
            mix_cnt_d = 2'd0;
            // The final round skips MixColumns.
            state_d   = (round_q == NR_L) ? S_ARK : S_MIX;
         end
         S_MIX: begin
            if (mix_cnt_q == MC_LAST) begin
               state_d   = S_ARK;
               mix_cnt_d = 2'd0;
            end else begin
               mix_cnt_d = mix_cnt_q + 2'd1;
            end
         end
         S_ARK: begin
            if (key_valid) begin
               if (round_q == NR_L) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SUB;
                  round_d = round_q + 4'd1;
               end
            end
         end
         S_DONE: begin
            // round reads NR during DONE and clears as IDLE is entered.
            state_d = S_IDLE;
            round_d = 4'd0;
         end
         default: begin
            state_d   = S_IDLE;
            round_d   = 4'd0;
            mix_cnt_d = 2'd0;
         end
      endcase
      // Abort wins over key_valid and the MIX counter.
      if (abort_hit && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         round_d   = 4'd0;
         mix_cnt_d = 2'd0;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         round_q   <= 4'd0;
         mix_cnt_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         round_q   <= round_d;
         mix_cnt_q <= mix_cnt_d;
      end
   end

   // Outputs decoded from registered state; only st_ld looks at key_valid.
   always_comb begin
      busy   = (state_q != S_IDLE);
      done   = (state_q == S_DONE);
      round  = round_q;
      mc_st  = (state_q == S_MIX);
      st_ld  = 1'b0;
      st_sel = SEL_IN;
      case (state_q)
         S_INIT: begin
            st_ld  = key_valid;
            st_sel = SEL_IN;
         end
         S_SUB: begin
            st_ld  = 1'b1;
            st_sel = SEL_SB;
         end
         S_ARK: begin
            st_ld  = key_valid;
            st_sel = (round_q == NR_L) ? SEL_KEY : SEL_MIX;
         end
         default: begin
            st_ld  = 1'b0;
            st_sel = SEL_IN;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Purpose: bench for aes_round_ctrl; two instances (MC_LAT=1 and MC_LAT=3) share stimulus.
// Latency: reference is a per-block phase script advanced once per clock, stalled where a key is needed.
// Backpressure: key_valid randomly withheld; abort scenario only when AES_ROUND_CTRL_ABORT_EN is defined.
module tb_aes_round_ctrl;

   localparam int NR = 10;

   localparam logic [2:0] K_INIT = 3'd0;
   localparam logic [2:0] K_SUB  = 3'd1;
   localparam logic [2:0] K_MIX  = 3'd2;
   localparam logic [2:0] K_ARK  = 3'd3;
   localparam logic [2:0] K_DONE = 3'd4;

   typedef struct packed {
      logic [2:0] kind;
      logic [3:0] rnd;
   } ph_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       key_valid = 1'b0;
   logic       abort_i = 1'b0;

   logic       busy0, done0, st_ld0, mc_st0;
   logic [3:0] round0;
   logic [1:0] st_sel0;
   logic       busy1, done1, st_ld1, mc_st1;
   logic [3:0] round1;
   logic [1:0] st_sel1;

   logic [9:0] obs [2];
   logic [9:0] exp_v [2];
   logic [9:0] msk_v [2];

   ph_t scr [2][64];
   int  len [2];
   int  ptr [2] = '{-1, -1};

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   aes_round_ctrl #(.NR(NR), .MC_LAT(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .key_valid(key_valid),
`ifdef AES_ROUND_CTRL_ABORT_EN
      .abort(abort_i),
`endif
      .busy(busy0), .done(done0), .round(round0), .st_ld(st_ld0), .st_sel(st_sel0), .mc_st(mc_st0)
   );

   aes_round_ctrl #(.NR(NR), .MC_LAT(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .key_valid(key_valid),
`ifdef AES_ROUND_CTRL_ABORT_EN
      .abort(abort_i),
`endif
      .busy(busy1), .done(done1), .round(round1), .st_ld(st_ld1), .st_sel(st_sel1), .mc_st(mc_st1)
   );

   assign obs[0] = {busy0, done0, round0, st_ld0, st_sel0, mc_st0};
   assign obs[1] = {busy1, done1, round1, st_ld1, st_sel1, mc_st1};

   // Expected outputs {busy,done,round,st_ld,st_sel,mc_st} and care-mask for the current phase.
   function automatic logic [19:0] model_out(input int d, input logic kv);
      logic [9:0] e;
      logic [9:0] m;
      ph_t        p;
      e = '0;
      m = '1;
      if (ptr[d] >= 0) begin
         p = scr[d][ptr[d]];
         case (p.kind)
            K_INIT: e = {1'b1, 1'b0, 4'd0, kv, 2'd0, 1'b0};
            K_SUB:  e = {1'b1, 1'b0, p.rnd, 1'b1, 2'd1, 1'b0};
            K_MIX: begin
               e = {1'b1, 1'b0, p.rnd, 1'b0, 2'd0, 1'b1};
               m[2:1] = 2'b00;
            end
            K_ARK:  e = {1'b1, 1'b0, p.rnd, kv, (p.rnd == 4'(NR)) ? 2'd3 : 2'd2, 1'b0};
            default: begin
               e = {1'b1, 1'b1, 4'(NR), 1'b0, 2'd0, 1'b0};
               m[2:1] = 2'b00;
            end
         endcase
      end
      return {e, m};
   endfunction

   task automatic build_scripts();
      int n;
      int ml;
      for (int d = 0; d < 2; d++) begin
         ml = (d == 0) ? 1 : 3;
         n = 0;
         scr[d][n] = {K_INIT, 4'd0}; n++;
         for (int r = 1; r < NR; r++) begin
            scr[d][n] = {K_SUB, 4'(r)}; n++;
            for (int k = 0; k < ml; k++) begin
               scr[d][n] = {K_MIX, 4'(r)}; n++;
            end
            scr[d][n] = {K_ARK, 4'(r)}; n++;
         end
         scr[d][n] = {K_SUB, 4'(NR)}; n++;
         scr[d][n] = {K_ARK, 4'(NR)}; n++;
         scr[d][n] = {K_DONE, 4'(NR)}; n++;
         len[d] = n;
      end
   endtask

   // Apply inputs just after the falling edge and compute the reference's expectation.
   task automatic drive(input logic s, input logic kv, input logic ab);
      logic [19:0] em;
      start     = s;
      key_valid = kv;
      abort_i   = ab;
      #1;
      for (int d = 0; d < 2; d++) begin
         em = model_out(d, kv);
         exp_v[d] = em[19:10];
         msk_v[d] = em[9:0];
      end
   endtask

   // Clock edge: advance the phase scripts with the inputs the DUTs sampled.
   task automatic tick();
      ph_t p;
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            ptr[d] = -1;
         end else if (ptr[d] < 0) begin
            if (start) ptr[d] = 0;
         end else if (abort_i) begin
            ptr[d] = -1;
         end else begin
            p = scr[d][ptr[d]];
            if (!(((p.kind == K_INIT) || (p.kind == K_ARK)) && !key_valid)) begin
               ptr[d]++;
               if (ptr[d] >= len[d]) ptr[d] = -1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while ((ptr[0] >= 0 || ptr[1] >= 0) && c < 200) begin
         drive(1'b0, 1'b1, 1'b0);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ((obs[d] & msk_v[d]) !== exp_v[d]) begin
               n_fail++;
               $display("FAIL drain d%0d c%0d got %h want %h", d, c, obs[d] & msk_v[d], exp_v[d]);
            end
         end
         tick();
         c++;
      end
      n_chk++;
      if (c >= 200) begin
         n_fail++;
         $display("FAIL drain_timeout got busy want idle");
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (obs[d] !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs d%0d got %h want 000", d, obs[d]);
         end
      end
      tick();
      tick();
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b0);
      n_chk++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || round0 !== 4'd0 || mc_st0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release got busy=%b done=%b round=%0d mc=%b want 0 0 0 0", busy0, done0, round0, mc_st0);
      end
      tick();
   endtask

   task automatic test_latency();
      int dc [2] = '{-1, -1};
      int dn [2] = '{0, 0};
      int mc [2] = '{0, 0};
      int bz [2] = '{0, 0};
      wait_idle();
      for (int c = 0; c < 70; c++) begin
         drive(c == 0, 1'b1, 1'b0);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ((obs[d] & msk_v[d]) !== exp_v[d]) begin
               n_fail++;
               $display("FAIL latency_cycle d%0d c%0d got %h want %h", d, c, obs[d] & msk_v[d], exp_v[d]);
            end
            if (obs[d][8]) begin dn[d]++; dc[d] = c; end
            mc[d] += int'(obs[d][0]);
            bz[d] += int'(obs[d][9]);
         end
         tick();
      end
      n_chk++;
      if (dn[0] !== 1 || dc[0] !== 31) begin
         n_fail++;
         $display("FAIL latency_done_lat1 got %0d pulses at %0d want 1 at 31", dn[0], dc[0]);
      end
      n_chk++;
      if (dn[1] !== 1 || dc[1] !== 49) begin
         n_fail++;
         $display("FAIL latency_done_lat3 got %0d pulses at %0d want 1 at 49", dn[1], dc[1]);
      end
      n_chk++;
      if (mc[0] !== 9 || mc[1] !== 27) begin
         n_fail++;
         $display("FAIL mc_st_count got %0d/%0d want 9/27", mc[0], mc[1]);
      end
      n_chk++;
      if (bz[0] !== 31 || bz[1] !== 49) begin
         n_fail++;
         $display("FAIL busy_count got %0d/%0d want 31/49", bz[0], bz[1]);
      end
   endtask

   task automatic test_key_stall();
      int   dc = -1;
      int   st = 0;
      logic kv;
      ph_t  p;
      wait_idle();
      for (int c = 0; c < 70; c++) begin
         kv = 1'b1;
         if (ptr[0] >= 0) begin
            p = scr[0][ptr[0]];
            if (p.kind == K_ARK && p.rnd == 4'd4 && st < 3) begin
               kv = 1'b0;
               st++;
            end
         end
         drive(c == 0, kv, 1'b0);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ((obs[d] & msk_v[d]) !== exp_v[d]) begin
               n_fail++;
               $display("FAIL stall_cycle d%0d c%0d got %h want %h", d, c, obs[d] & msk_v[d], exp_v[d]);
            end
         end
         if (!kv) begin
            n_chk++;
            if (st_ld0 !== 1'b0 || round0 !== 4'd4) begin
               n_fail++;
               $display("FAIL stall_hold c%0d got ld=%b round=%0d want ld=0 round=4", c, st_ld0, round0);
            end
         end
         if (done0) dc = c;
         tick();
      end
      n_chk++;
      if (dc !== 34) begin
         n_fail++;
         $display("FAIL stall_done_cycle got %0d want 34", dc);
      end
   endtask

   task automatic test_back_to_back();
      int dn = 0;
      int dc = -1;
      wait_idle();
      for (int c = 0; c < 60; c++) begin
         drive((c == 0) || (c == 5) || (c == 31), 1'b1, 1'b0);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ((obs[d] & msk_v[d]) !== exp_v[d]) begin
               n_fail++;
               $display("FAIL b2b_cycle d%0d c%0d got %h want %h", d, c, obs[d] & msk_v[d], exp_v[d]);
            end
         end
         if (done0) begin dn++; dc = c; end
         if (c == 32) begin
            n_chk++;
            if (busy0 !== 1'b0 || round0 !== 4'd0) begin
               n_fail++;
               $display("FAIL b2b_idle_32 got busy=%b round=%0d want busy=0 round=0", busy0, round0);
            end
         end
         tick();
      end
      n_chk++;
      if (dn !== 1 || dc !== 31) begin
         n_fail++;
         $display("FAIL b2b_done got %0d pulses at %0d want 1 at 31", dn, dc);
      end
   endtask

   task automatic test_async_reset();
      ph_t p;
      int  hit = 0;
      int  dn = 0;
      int  dc = -1;
      wait_idle();
      for (int c = 0; c < 60 && hit == 0; c++) begin
         drive(c == 0, 1'b1, 1'b0);
         if (done0 || done1) dn++;
         if (ptr[0] >= 0) begin
            p = scr[0][ptr[0]];
            if (p.kind == K_MIX && p.rnd == 4'd6) hit = 1;
         end
         if (hit == 0) tick();
      end
      n_chk++;
      if (hit == 0) begin
         n_fail++;
         $display("FAIL areset_reach got no MIX round 6 want MIX round 6");
      end
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (obs[d] !== 10'd0) begin
            n_fail++;
            $display("FAIL areset_outputs d%0d got %h want 000", d, obs[d]);
         end
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         drive(c == 1, 1'b1, 1'b0);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ((obs[d] & msk_v[d]) !== exp_v[d]) begin
               n_fail++;
               $display("FAIL areset_restart d%0d c%0d got %h want %h", d, c, obs[d] & msk_v[d], exp_v[d]);
            end
         end
         if (done0) dc = c;
         if (c == 0 && (done0 || done1)) dn++;
         tick();
      end
      n_chk++;
      if (dn !== 0 || dc !== 32) begin
         n_fail++;
         $display("FAIL areset_done got early=%0d cycle=%0d want early=0 cycle=32", dn, dc);
      end
   endtask

   task automatic test_random();
      int   blocks = 0;
      int   dn_obs = 0;
      int   dn_exp = 0;
      int   c = 0;
      logic s;
      logic kv;
      wait_idle();
      while ((blocks < 4 || ptr[0] >= 0 || ptr[1] >= 0) && c < 1500) begin
         if (ptr[0] < 0 && ptr[1] < 0 && blocks < 4) s = 1'($urandom_range(0, 1));
         else s = ($urandom_range(0, 9) == 0);
         kv = ($urandom_range(0, 3) != 0);
         drive(s, kv, 1'b0);
         if (s && ptr[0] < 0) blocks++;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ((obs[d] & msk_v[d]) !== exp_v[d]) begin
               n_fail++;
               $display("FAIL random_cycle d%0d c%0d got %h want %h", d, c, obs[d] & msk_v[d], exp_v[d]);
            end
         end
         dn_obs += int'(done0);
         dn_exp += int'(exp_v[0][8]);
         tick();
         c++;
      end
      n_chk++;
      if (c >= 1500 || dn_obs !== dn_exp) begin
         n_fail++;
         $display("FAIL random_done_count got %0d (cycles %0d) want %0d", dn_obs, c, dn_exp);
      end
   endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
   task automatic test_abort();
      int dn = 0;
      int dc = -1;
      wait_idle();
      for (int c = 0; c < 15; c++) begin
         drive(c == 0, 1'b1, c == 10);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ((obs[d] & msk_v[d]) !== exp_v[d]) begin
               n_fail++;
               $display("FAIL abort_cycle d%0d c%0d got %h want %h", d, c, obs[d] & msk_v[d], exp_v[d]);
            end
         end
         if (done0 || done1) dn++;
         if (c == 11) begin
            n_chk++;
            if (busy0 !== 1'b0 || round0 !== 4'd0 || busy1 !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_idle got busy=%b/%b round=%0d want 0/0 0", busy0, busy1, round0);
            end
         end
         tick();
      end
      for (int c = 0; c < 40; c++) begin
         drive(c == 0, 1'b1, 1'b0);
         if (done0) dc = c;
         tick();
      end
      n_chk++;
      if (dn !== 0 || dc !== 31) begin
         n_fail++;
         $display("FAIL abort_restart got aborted_done=%0d done_cycle=%0d want 0 31", dn, dc);
      end
   endtask
`endif

   initial begin
      build_scripts();
      test_reset();
      test_latency();
      test_key_stall();
      test_back_to_back();
      test_async_reset();
      test_random();
`ifdef AES_ROUND_CTRL_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion want summary");
      $fatal(1, "watchdog expired");
   end

endmodule
